// File: rtl/axis_fifo_occ.sv
// AXI4-Stream FIFO with live occupancy/frame counts, programmable almost-full/empty flags,
// synchronous flush and optional store-and-forward with a RAM-full release path.
module axis_fifo_occ #(
    parameter int DEPTH       = 1024,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit LAST_ENABLE = 1'b1,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1,
    parameter bit STORE_FWD   = 1'b0,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   cfg_afull_thresh,
    input  logic [ADDR_WIDTH:0]   cfg_aempty_thresh,
    output logic [ADDR_WIDTH:0]   status_occupancy,
    output logic [ADDR_WIDTH:0]   status_frames,
    output logic                  status_full,
    output logic                  status_empty,
    output logic                  status_almost_full,
    output logic                  status_almost_empty
);

    localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
    localparam int LAST_BIT   = USER_WIDTH;
    localparam int KEEP_LSB   = USER_WIDTH + 1;
    localparam int DATA_LSB   = USER_WIDTH + 1 + KEEP_WIDTH;

    localparam logic [ADDR_WIDTH:0] PTR_MSB = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    if (STORE_FWD && !LAST_ENABLE) begin : g_bad_store_fwd
        $error("axis_fifo_occ: STORE_FWD=1 requires LAST_ENABLE=1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_fifo_occ: DEPTH must be a power of 2 and at least 4");
    end

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic [ADDR_WIDTH:0]   frames_q, frames_d;
    logic [ADDR_WIDTH:0]   mem_frames_q, mem_frames_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_word_q;
    logic                  rdy_q;

    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] rd_word;
    logic                  ram_full;
    logic                  ram_empty;
    logic                  pop_allowed;
    logic                  wr_en;
    logic                  rd_en;
    logic                  out_xfer;
    logic                  in_last;
    logic                  rd_last;
    logic                  out_last;

    assign wr_word  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    assign rd_word  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_last  = rd_word[LAST_BIT];
    assign out_last = out_word_q[LAST_BIT];

    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);

    // rdy_q keeps the input closed while in reset and opens it from the first edge after release.
    assign s_axis_tready = rdy_q && !ram_full && !flush;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign in_last       = wr_en && s_axis_tlast;
    assign out_xfer      = out_valid_q && m_axis_tready && !flush;

    // The RAM-full release lets a frame longer than the RAM drain instead of deadlocking.
    assign pop_allowed = STORE_FWD ? ((mem_frames_q != '0) || ram_full) : 1'b1;
    assign rd_en       = (!out_valid_q || m_axis_tready) && !ram_empty && pop_allowed && !flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        frames_d     = frames_q;
        mem_frames_d = mem_frames_q;
        out_valid_d  = out_valid_q;

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            occ_d        = '0;
            frames_d     = '0;
            mem_frames_d = '0;
            out_valid_d  = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + CNT_ONE;
            end
            if (rd_en) begin
                rd_ptr_d    = rd_ptr_q + CNT_ONE;
                out_valid_d = 1'b1;
            end else if (out_xfer) begin
                out_valid_d = 1'b0;
            end

            unique case ({wr_en, out_xfer})
                2'b10:   occ_d = occ_q + CNT_ONE;
                2'b01:   occ_d = occ_q - CNT_ONE;
                default: occ_d = occ_q;
            endcase

            unique case ({in_last, rd_en && rd_last})
                2'b10:   mem_frames_d = mem_frames_q + CNT_ONE;
                2'b01:   mem_frames_d = mem_frames_q - CNT_ONE;
                default: mem_frames_d = mem_frames_q;
            endcase

            if (LAST_ENABLE) begin
                unique case ({in_last, out_xfer && out_last})
                    2'b10:   frames_d = frames_q + CNT_ONE;
                    2'b01:   frames_d = frames_q - CNT_ONE;
                    default: frames_d = frames_q;
                endcase
            end else begin
                frames_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            frames_q     <= '0;
            mem_frames_q <= '0;
            out_valid_q  <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            frames_q     <= frames_d;
            mem_frames_q <= mem_frames_d;
            out_valid_q  <= out_valid_d;
            rdy_q        <= 1'b1;
        end
    end

    // Storage and output payload carry no reset; only valid/pointers/counters do.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            out_word_q <= rd_word;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_word_q[DATA_LSB +: DATA_WIDTH];
    assign m_axis_tkeep  = KEEP_ENABLE ? out_word_q[KEEP_LSB +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
    assign m_axis_tlast  = LAST_ENABLE ? out_last : 1'b1;
    assign m_axis_tuser  = USER_ENABLE ? out_word_q[USER_WIDTH-1:0] : {USER_WIDTH{1'b0}};

    assign status_occupancy    = occ_q;
    assign status_frames       = frames_q;
    assign status_full         = ram_full;
    assign status_empty        = (occ_q == '0);
    assign status_almost_full  = (occ_q >= cfg_afull_thresh);
    assign status_almost_empty = (occ_q <= cfg_aempty_thresh);

endmodule

// File: tb/tb_axis_fifo_occ.sv
// Bench for axis_fifo_occ: a cut-through and a store-and-forward instance (DEPTH=16), each
// checked every cycle against a word-queue model of the FIFO.
module tb_axis_fifo_occ;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MB    = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_tready = 1'b0;
    logic       flush = 1'b0;
    logic [AW:0] afull_thr = '0;
    logic [AW:0] aempty_thr = 5'd2;

    logic [7:0]  s_tdata [2];
    logic [0:0]  s_tkeep [2];
    logic        s_tvalid [2];
    logic        s_tready [2];
    logic        s_tlast [2];
    logic [0:0]  s_tuser [2];
    logic [7:0]  m_tdata [2];
    logic [0:0]  m_tkeep [2];
    logic        m_tvalid [2];
    logic        m_tlast [2];
    logic [0:0]  m_tuser [2];
    logic [AW:0] occ [2];
    logic [AW:0] frm [2];
    logic        full [2];
    logic        empty [2];
    logic        afull [2];
    logic        aempty [2];

    always #5 clk = ~clk;

    axis_fifo_occ #(.DEPTH(DEPTH), .DATA_WIDTH(8), .STORE_FWD(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]),
        .flush(flush), .cfg_afull_thresh(afull_thr), .cfg_aempty_thresh(aempty_thr),
        .status_occupancy(occ[0]), .status_frames(frm[0]), .status_full(full[0]),
        .status_empty(empty[0]), .status_almost_full(afull[0]),
        .status_almost_empty(aempty[0])
    );

    axis_fifo_occ #(.DEPTH(DEPTH), .DATA_WIDTH(8), .STORE_FWD(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]),
        .flush(flush), .cfg_afull_thresh(afull_thr), .cfg_aempty_thresh(aempty_thr),
        .status_occupancy(occ[1]), .status_frames(frm[1]), .status_full(full[1]),
        .status_empty(empty[1]), .status_almost_full(afull[1]),
        .status_almost_empty(aempty[1])
    );

    // Model: words held in arrival order; the oldest sits in the output register when mov=1.
    logic [9:0] mbuf [2][MB];
    int         mhead [2];
    int         mcnt [2];
    bit         mov [2];
    bit         mrdy [2];
    bit         acc [2];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int count_last(input int i, input int from);
        int n = 0;
        for (int k = from; k < mcnt[i]; k++) begin
            if (mbuf[i][(mhead[i] + k) % MB][1]) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0;
            mhead[i] = 0;
            mov[i] = 1'b0;
            mrdy[i] = 1'b0;
            acc[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int ramc;
            logic [9:0] e;
            ramc = mcnt[i] - int'(mov[i]);
            chk("s_tready", i, s_tready[i], mrdy[i] && ramc != DEPTH && !flush);
            chk("m_tvalid", i, m_tvalid[i], mov[i]);
            chk("occupancy", i, occ[i], mcnt[i]);
            chk("frames", i, frm[i], count_last(i, 0));
            chk("full", i, full[i], ramc == DEPTH);
            chk("empty", i, empty[i], mcnt[i] == 0);
            chk("almost_full", i, afull[i], mcnt[i] >= int'(afull_thr));
            chk("almost_empty", i, aempty[i], mcnt[i] <= int'(aempty_thr));
            chk("tkeep", i, m_tkeep[i], 1);
            if (mov[i]) begin
                e = mbuf[i][mhead[i]];
                chk("tdata", i, m_tdata[i], e[9:2]);
                chk("tlast", i, m_tlast[i], e[1]);
                chk("tuser", i, m_tuser[i], e[0]);
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        bit w [2];
        bit x [2];
        bit ld [2];
        logic [9:0] word [2];
        for (int i = 0; i < 2; i++) begin
            int ramc;
            bit rfull;
            bit pa;
            ramc = mcnt[i] - int'(mov[i]);
            rfull = (ramc == DEPTH);
            word[i] = {s_tdata[i], s_tlast[i], s_tuser[i]};
            w[i] = s_tvalid[i] && mrdy[i] && !rfull && !flush;
            x[i] = mov[i] && m_tready;
            pa = (i == 0) || count_last(i, int'(mov[i])) != 0 || rfull;
            ld[i] = (!mov[i] || m_tready) && ramc != 0 && pa;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            if (rst_n) begin
                if (flush) begin
                    mcnt[i] = 0;
                    mov[i] = 1'b0;
                end else begin
                    if (x[i]) begin
                        mhead[i] = (mhead[i] + 1) % MB;
                        mcnt[i]--;
                    end
                    if (w[i]) begin
                        mbuf[i][(mhead[i] + mcnt[i]) % MB] = word[i];
                        mcnt[i]++;
                        acc[i] = 1'b1;
                    end
                    if (ld[i]) mov[i] = 1'b1;
                    else if (x[i]) mov[i] = 1'b0;
                end
                mrdy[i] = 1'b1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 2; i++) s_tvalid[i] = 1'b0;
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic offer(input int n, input int vpct, input int lpct);
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 2; i++) begin
                s_tvalid[i] = ($urandom_range(99) < vpct);
                s_tdata[i]  = 8'($urandom);
                s_tlast[i]  = ($urandom_range(99) < lpct);
                s_tuser[i]  = 1'($urandom);
                s_tkeep[i]  = 1'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) s_tvalid[i] = 1'b0;
    endtask

    // Handshaked frame source per instance; the last beat is held back for 'gap' cycles.
    task automatic send_frame(input int len, input int gap, input logic [7:0] base);
        int sent [2];
        int gapl [2];
        int t = 0;
        sent[0] = 0; sent[1] = 0; gapl[0] = gap; gapl[1] = gap;
        while (t < 600 && !(sent[0] >= len && sent[1] >= len)) begin
            for (int i = 0; i < 2; i++) begin
                if (sent[i] >= len) begin
                    s_tvalid[i] = 1'b0;
                end else if (sent[i] == len - 1 && gapl[i] > 0) begin
                    s_tvalid[i] = 1'b0;
                    gapl[i]--;
                end else begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = base + 8'(sent[i]);
                    s_tlast[i]  = (sent[i] == len - 1);
                    s_tuser[i]  = s_tdata[i][0];
                    s_tkeep[i]  = 1'b0;
                end
            end
            tick();
            for (int i = 0; i < 2; i++) if (acc[i]) sent[i]++;
            t++;
        end
        chk("send_done", 0, sent[0] >= len && sent[1] >= len, 1);
        for (int i = 0; i < 2; i++) s_tvalid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tlast[i] = 1'b0;
            s_tuser[i] = '0; s_tkeep[i] = '0;
        end
        model_reset();

        // Reset state, with afull threshold 0 and then 12
        #2 check_all();
        afull_thr = 5'd12;
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Five words with the sink stalled, then drained in order
        m_tready = 1'b0;
        send_frame(5, 0, 8'h01);
        chk("occ_after_5", 0, occ[0], 5);
        m_tready = 1'b1;
        idle(10);

        // Fill to DEPTH+1, release one word, then stream while near full
        m_tready = 1'b0;
        offer(22, 100, 25);
        chk("fill_occ", 0, occ[0], DEPTH + 1);
        chk("fill_full", 0, full[0], 1);
        chk("fill_tready", 0, s_tready[0], 0);
        m_tready = 1'b1;
        idle(1);
        chk("reopen_tready", 0, s_tready[0], 1);
        offer(6, 100, 25);
        m_tready = 1'b1;
        idle(25);

        // Frame whose tlast is delayed 10 cycles, then a 40-beat frame through a 16-deep RAM
        send_frame(4, 10, 8'h40);
        idle(8);
        send_frame(40, 0, 8'h80);
        idle(30);

        // Occupancy ramp 0 -> 17 -> 0 for the almost flags
        m_tready = 1'b0;
        offer(20, 100, 100);
        m_tready = 1'b1;
        idle(22);

        // Randomised mix with occasional flushes
        for (int t = 0; t < 400; t++) begin
            m_tready = ($urandom_range(99) < 60);
            flush = ($urandom_range(49) == 0);
            offer(1, 70, 30);
        end
        flush = 1'b0;

        // Explicit one-cycle flush with a beat offered
        m_tready = 1'b0;
        offer(6, 100, 0);
        flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b1; s_tdata[i] = 8'hEE; s_tlast[i] = 1'b1;
        end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) s_tvalid[i] = 1'b0;
        chk("flush_occ", 0, occ[0], 0);
        chk("flush_valid", 1, m_tvalid[1], 0);
        m_tready = 1'b1;
        send_frame(3, 0, 8'h20);
        idle(6);

        // Asynchronous reset mid-frame
        m_tready = 1'b0;
        offer(5, 100, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("areset_occ", 1, occ[1], 0);
        idle(1);
        rst_n = 1'b1;
        m_tready = 1'b1;
        send_frame(5, 0, 8'h60);
        idle(10);

        m_tready = 1'b1;
        flush = 1'b0;
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
